// File: rtl/core_biu_arb_pkg.sv
// Shared encodings for the core bus-interface arbiter: FSM states, owner
// identifiers and the grant-selection rule.
package core_biu_arb_pkg;

    typedef enum logic [1:0] {
        CORE_BIU_IDLE = 2'b00,
        CORE_BIU_REQ  = 2'b01,
        CORE_BIU_RESP = 2'b10
    } biu_state_e;

    typedef enum logic {
        CORE_BIU_OWN_IFU = 1'b0,
        CORE_BIU_OWN_LSU = 1'b1
    } biu_owner_e;

    // LSU wins unless IFU has been starved; an idle arbiter defaults to LSU.
    function automatic biu_owner_e pick_owner(input logic ifu_v, input logic lsu_v,
                                              input logic starved);
        biu_owner_e own;
        if (lsu_v && !(starved && ifu_v)) begin
            own = CORE_BIU_OWN_LSU;
        end else if (ifu_v) begin
            own = CORE_BIU_OWN_IFU;
        end else begin
            own = CORE_BIU_OWN_LSU;
        end
        return own;
    endfunction

endpackage

// File: rtl/core_biu_arb_grant.sv
// Grant selection with the IFU anti-starvation counter: counts LSU grants
// taken while IFU waits, and hands IFU the next grant once the limit is hit.
module core_biu_arb_grant
    import core_biu_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_ifu_valid,
    input  logic       i_lsu_valid,
    input  logic       i_accept,
    input  biu_owner_e i_owner,
    output biu_owner_e o_grant
);

    localparam int              CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] r_starve_cnt;
    logic             w_starved;

    assign w_starved = (r_starve_cnt == LIMIT);
    assign o_grant   = pick_owner(i_ifu_valid, i_lsu_valid, w_starved);

    // Saturating count of LSU wins over a waiting IFU; any other grant clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (i_accept) begin
            if ((i_owner == CORE_BIU_OWN_LSU) && i_ifu_valid) begin
                if (!w_starved) begin
                    r_starve_cnt <= r_starve_cnt + CNT_W'(1);
                end else begin
                    r_starve_cnt <= r_starve_cnt;
                end
            end else begin
                r_starve_cnt <= '0;
            end
        end else begin
            r_starve_cnt <= r_starve_cnt;
        end
    end

endmodule

// File: rtl/core_biu_arb.sv
// Arbitrates the single memory port between instruction fetch and load/store,
// one transaction in flight, dropping fetch responses made stale by a flush.
module core_biu_arb
    import core_biu_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_req_addr,
    input  logic                ifu_flush,
    output logic                ifu_rsp_valid,
    output logic [DATA_W-1:0]   ifu_rsp_rdata,
    output logic                ifu_rsp_err,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_req_addr,
    input  logic                lsu_req_wen,
    input  logic [DATA_W-1:0]   lsu_req_wdata,
    input  logic [DATA_W/8-1:0] lsu_req_wstrb,
    output logic                lsu_rsp_valid,
    output logic [DATA_W-1:0]   lsu_rsp_rdata,
    output logic                lsu_rsp_err,
    output logic                bus_req_valid,
    input  logic                bus_req_ready,
    output logic [ADDR_W-1:0]   bus_req_addr,
    output logic                bus_req_wen,
    output logic [DATA_W-1:0]   bus_req_wdata,
    output logic [DATA_W/8-1:0] bus_req_wstrb,
    input  logic                bus_rsp_valid,
    input  logic [DATA_W-1:0]   bus_rsp_rdata,
    input  logic                bus_rsp_err,
    output logic                arb_busy
);

    biu_state_e          r_state;
    biu_state_e          w_next_state;
    biu_owner_e          r_owner;
    biu_owner_e          w_grant;
    logic                r_drop;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_wen;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W/8-1:0] r_wstrb;
    logic                w_accept;
    logic                w_rsp_fire;

    core_biu_arb_grant #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_grant (
        .clk         (clk),
        .rst         (rst),
        .i_ifu_valid (ifu_req_valid),
        .i_lsu_valid (lsu_req_valid),
        .i_accept    (w_accept),
        .i_owner     (w_grant),
        .o_grant     (w_grant)
    );

    // Readies depend only on state and grant, never on the bus side.
    assign ifu_req_ready = (r_state == CORE_BIU_IDLE) && (w_grant == CORE_BIU_OWN_IFU) && !ifu_flush;
    assign lsu_req_ready = (r_state == CORE_BIU_IDLE) && (w_grant == CORE_BIU_OWN_LSU);
    assign w_accept      = (ifu_req_valid && ifu_req_ready) || (lsu_req_valid && lsu_req_ready);

    assign bus_req_valid = (r_state == CORE_BIU_REQ);
    assign bus_req_addr  = r_addr;
    assign bus_req_wen   = r_wen;
    assign bus_req_wdata = r_wdata;
    assign bus_req_wstrb = r_wstrb;
    assign arb_busy      = (r_state != CORE_BIU_IDLE);

    // A flush in the response cycle itself also suppresses the fetch response.
    assign w_rsp_fire    = (r_state == CORE_BIU_RESP) && bus_rsp_valid;
    assign ifu_rsp_valid = w_rsp_fire && (r_owner == CORE_BIU_OWN_IFU) && !r_drop && !ifu_flush;
    assign lsu_rsp_valid = w_rsp_fire && (r_owner == CORE_BIU_OWN_LSU);
    assign ifu_rsp_rdata = ifu_rsp_valid ? bus_rsp_rdata : '0;
    assign ifu_rsp_err   = ifu_rsp_valid ? bus_rsp_err : 1'b0;
    assign lsu_rsp_rdata = lsu_rsp_valid ? bus_rsp_rdata : '0;
    assign lsu_rsp_err   = lsu_rsp_valid ? bus_rsp_err : 1'b0;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= CORE_BIU_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            CORE_BIU_IDLE: w_next_state = w_accept      ? CORE_BIU_REQ  : CORE_BIU_IDLE;
            CORE_BIU_REQ:  w_next_state = bus_req_ready ? CORE_BIU_RESP : CORE_BIU_REQ;
            CORE_BIU_RESP: w_next_state = bus_rsp_valid ? CORE_BIU_IDLE : CORE_BIU_RESP;
            default:       w_next_state = CORE_BIU_IDLE;
        endcase
    end

    // Capture the granted request; fetches are always full-word reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner <= CORE_BIU_OWN_LSU;
            r_addr  <= '0;
            r_wen   <= 1'b0;
            r_wdata <= '0;
            r_wstrb <= '0;
        end else if (w_accept) begin
            r_owner <= w_grant;
            if (w_grant == CORE_BIU_OWN_IFU) begin
                r_addr  <= ifu_req_addr;
                r_wen   <= 1'b0;
                r_wdata <= '0;
                r_wstrb <= '0;
            end else begin
                r_addr  <= lsu_req_addr;
                r_wen   <= lsu_req_wen;
                r_wdata <= lsu_req_wdata;
                r_wstrb <= lsu_req_wstrb;
            end
        end else begin
            r_owner <= r_owner;
            r_addr  <= r_addr;
            r_wen   <= r_wen;
            r_wdata <= r_wdata;
            r_wstrb <= r_wstrb;
        end
    end

    // Remember a flush that hit an in-flight fetch until the arbiter idles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop <= 1'b0;
        end else if (w_next_state == CORE_BIU_IDLE) begin
            r_drop <= 1'b0;
        end else if ((r_state != CORE_BIU_IDLE) && (r_owner == CORE_BIU_OWN_IFU) && ifu_flush) begin
            r_drop <= 1'b1;
        end else begin
            r_drop <= r_drop;
        end
    end

endmodule

// File: tb/tb_core_biu_arb.sv
// Randomized scoreboard bench for core_biu_arb with a transaction-level model
// and directed backpressure, async-reset and contention phases.
module tb_core_biu_arb;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = 4;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          ifu_req_valid, ifu_req_ready, ifu_flush;
    logic [AW-1:0] ifu_req_addr;
    logic          ifu_rsp_valid, ifu_rsp_err;
    logic [DW-1:0] ifu_rsp_rdata;
    logic          lsu_req_valid, lsu_req_ready, lsu_req_wen;
    logic [AW-1:0] lsu_req_addr;
    logic [DW-1:0] lsu_req_wdata;
    logic [SW-1:0] lsu_req_wstrb;
    logic          lsu_rsp_valid, lsu_rsp_err;
    logic [DW-1:0] lsu_rsp_rdata;
    logic          bus_req_valid, bus_req_ready, bus_req_wen;
    logic [AW-1:0] bus_req_addr;
    logic [DW-1:0] bus_req_wdata;
    logic [SW-1:0] bus_req_wstrb;
    logic          bus_rsp_valid, bus_rsp_err;
    logic [DW-1:0] bus_rsp_rdata;
    logic          arb_busy;

    always #5 clk = ~clk;

    core_biu_arb #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
        .ifu_flush(ifu_flush),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_rdata(ifu_rsp_rdata), .ifu_rsp_err(ifu_rsp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
        .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wstrb(lsu_req_wstrb),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_rdata(lsu_rsp_rdata), .lsu_rsp_err(lsu_rsp_err),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_req_addr(bus_req_addr),
        .bus_req_wen(bus_req_wen), .bus_req_wdata(bus_req_wdata), .bus_req_wstrb(bus_req_wstrb),
        .bus_rsp_valid(bus_rsp_valid), .bus_rsp_rdata(bus_rsp_rdata), .bus_rsp_err(bus_rsp_err),
        .arb_busy(arb_busy)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic          wen;
        logic [DW-1:0] wdata;
        logic [SW-1:0] wstrb;
        bit            own_ifu;
    } txn_t;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
    } rsp_t;

    rsp_t ifu_q[$];
    rsp_t lsu_q[$];
    bit   grant_log[$];

    int   n_cmp = 0;
    int   n_bad = 0;

    // Model state: one open transaction with phase 1 = waiting for bus
    // handshake, 2 = waiting for response.
    txn_t cur;
    bit   open_txn = 1'b0;
    int   phase = 0;
    bit   drop = 1'b0;
    int   cnt = 0;
    bit   mon_en = 1'b0;
    bit   log_en = 1'b0;
    bit   hs_ifu = 1'b0, hs_lsu = 1'b0;
    bit   ifu_pend = 1'b0, lsu_pend = 1'b0;
    int   p_ifu, p_lsu, p_flush, p_bready, p_rsp, p_noise;

    bit   open_start, pred_ifu, e_ifu_hs, e_lsu_hs;
    rsp_t r;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard, sampling mid-cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            open_start = open_txn;
            chk("arb_busy", arb_busy, open_txn);
            if (open_txn) begin
                chk("ifu_ready_while_busy", ifu_req_ready, 1'b0);
                chk("lsu_ready_while_busy", lsu_req_ready, 1'b0);
                if (cur.own_ifu && ifu_flush) drop = 1'b1;
            end
            chk("bus_req_valid", bus_req_valid, open_txn && (phase == 1));
            if (open_txn && (phase == 1)) begin
                chk("bus_addr", bus_req_addr, cur.addr);
                chk("bus_wen", bus_req_wen, cur.wen);
                chk("bus_wstrb", bus_req_wstrb, cur.wstrb);
                if (!cur.own_ifu) chk("bus_wdata", bus_req_wdata, cur.wdata);
            end
            if (open_txn && (phase == 2) && bus_rsp_valid) begin
                if (!cur.own_ifu) lsu_q.push_back('{rdata: bus_rsp_rdata, err: bus_rsp_err});
                else if (!drop)   ifu_q.push_back('{rdata: bus_rsp_rdata, err: bus_rsp_err});
                open_txn = 1'b0;
                phase    = 0;
                drop     = 1'b0;
            end else if (open_txn && (phase == 1) && bus_req_ready) begin
                phase = 2;
            end

            if (ifu_rsp_valid) begin
                if (ifu_q.size() == 0) begin
                    chk("ifu_rsp_unexpected", 1'b1, 1'b0);
                end else begin
                    r = ifu_q.pop_front();
                    chk("ifu_rsp_rdata", ifu_rsp_rdata, r.rdata);
                    chk("ifu_rsp_err", ifu_rsp_err, r.err);
                end
            end else begin
                chk("ifu_rdata_idle", {ifu_rsp_err, ifu_rsp_rdata}, 33'h0);
            end
            if (lsu_rsp_valid) begin
                if (lsu_q.size() == 0) begin
                    chk("lsu_rsp_unexpected", 1'b1, 1'b0);
                end else begin
                    r = lsu_q.pop_front();
                    chk("lsu_rsp_rdata", lsu_rsp_rdata, r.rdata);
                    chk("lsu_rsp_err", lsu_rsp_err, r.err);
                end
            end else begin
                chk("lsu_rdata_idle", {lsu_rsp_err, lsu_rsp_rdata}, 33'h0);
            end

            if (!open_start) begin
                pred_ifu = (lsu_req_valid && !((cnt == LIM) && ifu_req_valid)) ? 1'b0 : ifu_req_valid;
                e_ifu_hs = ifu_req_valid && pred_ifu && !ifu_flush;
                e_lsu_hs = lsu_req_valid && !pred_ifu;
                chk("ifu_handshake", ifu_req_valid && ifu_req_ready, e_ifu_hs);
                chk("lsu_handshake", lsu_req_valid && lsu_req_ready, e_lsu_hs);
                if (e_ifu_hs) begin
                    cur      = '{addr: ifu_req_addr, wen: 1'b0, wdata: '0, wstrb: '0, own_ifu: 1'b1};
                    cnt      = 0;
                    open_txn = 1'b1;
                    phase    = 1;
                    hs_ifu   = 1'b1;
                    if (log_en) grant_log.push_back(1'b1);
                end else if (e_lsu_hs) begin
                    cur      = '{addr: lsu_req_addr, wen: lsu_req_wen, wdata: lsu_req_wdata,
                                 wstrb: lsu_req_wstrb, own_ifu: 1'b0};
                    cnt      = ifu_req_valid ? ((cnt < LIM) ? cnt + 1 : LIM) : 0;
                    open_txn = 1'b1;
                    phase    = 1;
                    hs_lsu   = 1'b1;
                    if (log_en) grant_log.push_back(1'b0);
                end
            end
        end
    end

    task automatic step();
        if (hs_ifu) begin ifu_pend = 1'b0; hs_ifu = 1'b0; end
        if (hs_lsu) begin lsu_pend = 1'b0; hs_lsu = 1'b0; end
        if (!ifu_pend && ($urandom % 100 < p_ifu)) begin
            ifu_pend     = 1'b1;
            ifu_req_addr = $urandom & 32'hFFFF_FFFC;
        end
        if (!lsu_pend && ($urandom % 100 < p_lsu)) begin
            lsu_pend      = 1'b1;
            lsu_req_addr  = $urandom;
            lsu_req_wen   = 1'($urandom % 2);
            lsu_req_wdata = $urandom;
            lsu_req_wstrb = 4'($urandom);
        end
        ifu_req_valid = ifu_pend;
        lsu_req_valid = lsu_pend;
        ifu_flush     = ($urandom % 100 < p_flush);
        bus_req_ready = ($urandom % 100 < p_bready);
        bus_rsp_valid = (phase == 2) ? ($urandom % 100 < p_rsp) : ($urandom % 100 < p_noise);
        bus_rsp_rdata = $urandom;
        bus_rsp_err   = ($urandom % 4 == 0);
    endtask

    task automatic drive_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            step();
        end
    endtask

    task automatic drain();
        p_ifu = 0; p_lsu = 0; p_flush = 0; p_bready = 100; p_rsp = 100; p_noise = 0;
        for (int i = 0; i < 200 && (open_txn || ifu_pend || lsu_pend); i++) drive_cycles(1);
        drive_cycles(2);
        chk("drain_timeout", open_txn || ifu_pend || lsu_pend, 1'b0);
        chk("ifu_rsp_missing", ifu_q.size(), 0);
        chk("lsu_rsp_missing", lsu_q.size(), 0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
    endtask

    initial begin
        bit pat[10];
        pat = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        rst = 1'b1;
        ifu_req_valid = 1'b0; ifu_req_addr = '0; ifu_flush = 1'b0;
        lsu_req_valid = 1'b0; lsu_req_addr = '0; lsu_req_wen = 1'b0;
        lsu_req_wdata = '0; lsu_req_wstrb = '0;
        bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_rdata = '0; bus_rsp_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_bus_req_valid", bus_req_valid, 1'b0);
        chk("rst_arb_busy", arb_busy, 1'b0);
        chk("rst_rsp_valid", {ifu_rsp_valid, lsu_rsp_valid}, 2'b00);
        chk("rst_rsp_data", {ifu_rsp_rdata, lsu_rsp_rdata}, 64'h0);
        chk("rst_bus_fields", {bus_req_addr, bus_req_wen, bus_req_wstrb}, 37'h0);
        release_reset();

        // Random mixed traffic with flushes, backpressure and response noise.
        p_ifu = 60; p_lsu = 60; p_flush = 15; p_bready = 60; p_rsp = 50; p_noise = 10;
        drive_cycles(1500);
        drain();

        // LSU-only traffic held off by the bus for several cycles.
        p_ifu = 0; p_lsu = 100; p_flush = 0; p_bready = 0; p_rsp = 100; p_noise = 0;
        drive_cycles(6);
        p_bready = 100;
        drive_cycles(6);
        drain();

        // Reset asserted while a request sits on the bus.
        p_ifu = 0; p_lsu = 100; p_flush = 0; p_bready = 0; p_rsp = 0; p_noise = 0;
        for (int i = 0; i < 20 && phase != 1; i++) drive_cycles(1);
        chk("reached_req_phase", phase, 1);
        #2;
        mon_en = 1'b0;
        rst    = 1'b1;
        #1;
        chk("async_rst_bus_req_valid", bus_req_valid, 1'b0);
        chk("async_rst_arb_busy", arb_busy, 1'b0);
        chk("async_rst_rsp_valid", {ifu_rsp_valid, lsu_rsp_valid}, 2'b00);
        open_txn = 1'b0; phase = 0; drop = 1'b0; cnt = 0;
        hs_ifu = 1'b0; hs_lsu = 1'b0; ifu_pend = 1'b0; lsu_pend = 1'b0;
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
        ifu_q.delete();
        lsu_q.delete();
        release_reset();

        // Both requesters saturated: starvation counter forces every fifth grant to IFU.
        grant_log.delete();
        log_en = 1'b1;
        p_ifu = 100; p_lsu = 100; p_flush = 0; p_bready = 100; p_rsp = 100; p_noise = 0;
        drive_cycles(40);
        log_en = 1'b0;
        chk("contention_grant_count", grant_log.size() >= 10, 1'b1);
        for (int i = 0; i < 10 && i < grant_log.size(); i++) chk($sformatf("contention_grant_%0d", i), grant_log[i], pat[i]);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
